// File: rtl/serial_frame_deserializer.sv
// Serial-to-parallel receive stage: rebuilds MSB-first WIDTH-bit words and tags each
// with its position inside a FRAME_LEN-sample FFT frame.
module serial_frame_deserializer #(
    parameter int WIDTH     = 16,
    parameter int FRAME_LEN = 32,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_start,
    input  logic             in_bit,
    input  logic             frame_clr,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic [IDX_W-1:0] sample_idx,
    output logic             frame_done,
    output logic             sync_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   sample_out_q, sample_out_d;
    logic [IDX_W-1:0]   sample_idx_q, sample_idx_d;
    logic               sample_valid_q, sample_valid_d;
    logic               frame_done_q, frame_done_d;
    logic               sync_err_q, sync_err_d;
    logic               last_word;

    assign last_word = (word_cnt_q == IDX_W'(FRAME_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            word_cnt_q     <= '0;
            shift_q        <= '0;
            sample_out_q   <= '0;
            sample_idx_q   <= '0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            word_cnt_q     <= word_cnt_d;
            shift_q        <= shift_d;
            sample_out_q   <= sample_out_d;
            sample_idx_q   <= sample_idx_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            sync_err_q     <= sync_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        word_cnt_d     = word_cnt_q;
        shift_d        = shift_q;
        sample_out_d   = sample_out_q;
        sample_idx_d   = sample_idx_q;
        sample_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        sync_err_d     = 1'b0;

        // Realign overrides any start, error or completion in the same cycle.
        if (frame_clr) begin
            word_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_start) begin
                        shift_d   = {{(WIDTH-1){1'b0}}, in_bit};
                        bit_cnt_d = CNT_W'(1);
                        state_d   = RECV;
                    end
                end
                RECV: begin
                    if (in_start) begin
                        sync_err_d = 1'b1;
                        shift_d    = {{(WIDTH-1){1'b0}}, in_bit};
                        bit_cnt_d  = CNT_W'(1);
                    end else begin
                        shift_d   = {shift_q[WIDTH-2:0], in_bit};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                            sample_out_d   = {shift_q[WIDTH-2:0], in_bit};
                            sample_valid_d = 1'b1;
                            sample_idx_d   = word_cnt_q;
                            frame_done_d   = last_word;
                            word_cnt_d     = last_word ? '0 : word_cnt_q + IDX_W'(1);
                            bit_cnt_d      = '0;
                            state_d        = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign frame_done   = frame_done_q;
    assign sync_err     = sync_err_q;
    assign busy         = (state_q == RECV);

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: per-scenario tasks with inline checks.
module tb_serial_frame_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic        in_bit = 1'b0;
    logic        frame_clr = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [4:0]  sample_idx;
    logic        frame_done;
    logic        sync_err;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [15:0] q_val[$];
    logic [4:0]  q_idx[$];
    logic        q_fd[$];
    int          q_cyc[$];
    int          serr_cnt = 0;

    serial_frame_deserializer #(.WIDTH(16), .FRAME_LEN(32), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_bit(in_bit),
        .frame_clr(frame_clr), .sample_out(sample_out), .sample_valid(sample_valid),
        .sample_idx(sample_idx), .frame_done(frame_done), .sync_err(sync_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (sample_valid) begin
            q_val.push_back(sample_out);
            q_idx.push_back(sample_idx);
            q_fd.push_back(frame_done);
            q_cyc.push_back(cyc);
        end
        if (sync_err) serr_cnt <= serr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic tick(input logic s, input logic b, input logic c);
        in_start  = s;
        in_bit    = b;
        frame_clr = c;
        @(negedge clk);
        in_start  = 1'b0;
        in_bit    = 1'b0;
        frame_clr = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) tick(i == 0, w[15-i], 1'b0);
    endtask

    task automatic clear_mon();
        q_val.delete(); q_idx.delete(); q_fd.delete(); q_cyc.delete();
        serr_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({sample_out, sample_valid, sample_idx, frame_done, sync_err, busy} !== 26'd0) begin
            $display("FAIL reset_outputs: got out=%0h v=%0b idx=%0d fd=%0b se=%0b busy=%0b expected all 0",
                     sample_out, sample_valid, sample_idx, frame_done, sync_err, busy);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released: busy=%0b", busy);
    endtask

    task automatic test_single_word();
        logic [15:0] w;
        int busy_bad;
        int valid_bad;
        w = 16'h8001;
        busy_bad = 0;
        valid_bad = 0;
        clear_mon();
        for (int i = 0; i < 16; i++) begin
            tick(i == 0, w[15-i], 1'b0);
            if (i < 15 && (busy !== 1'b1 || sample_valid !== 1'b0)) busy_bad++;
            if (i == 15 && (busy !== 1'b0 || sample_valid !== 1'b1)) valid_bad++;
        end
        check("single_busy_window", busy_bad, 0);
        check("single_valid_timing", valid_bad, 0);
        tick(0, 0, 0);
        check("single_valid_pulse_count", q_val.size(), 1);
        if (q_val.size() == 1) begin
            check("single_value", q_val[0], 16'h8001);
            check("single_idx", q_idx[0], 0);
            check("single_frame_done", q_fd[0], 0);
        end
        $display("single word: %0d strobes, value %0d", q_val.size(),
                 (q_val.size() > 0) ? $signed(q_val[0]) : 0);
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] w;
        w = 16'hA5A5;
        for (int i = 0; i < 7; i++) tick(i == 0, w[15-i], 1'b0);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({sample_out, sample_valid, sample_idx, frame_done, sync_err, busy} !== 26'd0) begin
            $display("FAIL async_reset_outputs: got out=%0h idx=%0d busy=%0b expected all 0",
                     sample_out, sample_idx, busy);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_mon();
        send_word(16'h1234);
        tick(0, 0, 0);
        check("after_reset_count", q_val.size(), 1);
        if (q_val.size() == 1) begin
            check("after_reset_value", q_val[0], 16'h1234);
            check("after_reset_idx", q_idx[0], 0);
        end
        check("after_reset_sync_err", serr_cnt, 0);
        $display("reset mid-word: next word idx=%0d", (q_idx.size() > 0) ? q_idx[0] : 5'd31);
    endtask

    task automatic test_full_frame();
        int idx_bad;
        int val_bad;
        int fd_bad;
        tick(0, 0, 1);
        clear_mon();
        for (int i = 0; i < 33; i++) send_word(16'(i));
        tick(0, 0, 0);
        check("frame_strobes", q_val.size(), 33);
        idx_bad = 0; val_bad = 0; fd_bad = 0;
        for (int i = 0; i < q_val.size() && i < 33; i++) begin
            if (q_idx[i] !== 5'(i % 32)) idx_bad++;
            if (q_val[i] !== 16'(i)) val_bad++;
            if (q_fd[i] !== (i == 31)) fd_bad++;
        end
        check("frame_idx_sequence", idx_bad, 0);
        check("frame_values", val_bad, 0);
        check("frame_done_only_at_31", fd_bad, 0);
        check("frame_no_sync_err", serr_cnt, 0);
        $display("full frame: %0d strobes, last idx=%0d", q_val.size(),
                 (q_idx.size() > 0) ? q_idx[q_idx.size()-1] : 5'd0);
    endtask

    task automatic test_sync_err();
        logic [15:0] junk;
        junk = 16'hAAAA;
        clear_mon();
        for (int i = 0; i < 7; i++) tick(i == 0, junk[15-i], 1'b0);
        send_word(16'h7FFF);
        tick(0, 0, 0);
        check("sync_err_pulses", serr_cnt, 1);
        check("sync_valid_count", q_val.size(), 1);
        if (q_val.size() == 1) begin
            check("sync_value", q_val[0], 16'h7FFF);
            check("sync_idx", q_idx[0], 1);
        end
        $display("sync error: %0d pulses, %0d strobes", serr_cnt, q_val.size());
    endtask

    task automatic test_realign();
        logic [15:0] w;
        tick(0, 0, 1);
        clear_mon();
        for (int i = 0; i < 5; i++) send_word(16'h0100 + 16'(i));
        tick(0, 0, 0);
        check("realign_pre_count", q_val.size(), 5);
        if (q_val.size() == 5) check("realign_pre_last_idx", q_idx[4], 4);
        clear_mon();
        w = 16'hFFFF;
        for (int i = 0; i < 3; i++) tick(i == 0, w[15-i], 1'b0);
        tick(1, 1, 1);
        tick(0, 0, 0);
        check("realign_busy", busy, 0);
        // Completion coinciding with frame_clr must be dropped as well.
        for (int i = 0; i < 15; i++) tick(i == 0, w[15-i], 1'b0);
        tick(0, 1, 1);
        tick(0, 0, 0);
        check("realign_no_valid", q_val.size(), 0);
        check("realign_no_sync_err", serr_cnt, 0);
        send_word(16'h0F0F);
        tick(0, 0, 0);
        check("realign_next_count", q_val.size(), 1);
        if (q_val.size() == 1) begin
            check("realign_next_idx", q_idx[0], 0);
            check("realign_next_value", q_val[0], 16'h0F0F);
        end
        $display("realign: next idx=%0d", (q_idx.size() > 0) ? q_idx[0] : 5'd31);
    endtask

    task automatic test_back_to_back_neg();
        clear_mon();
        send_word(16'h8000);
        send_word(16'hFFFF);
        tick(0, 0, 0);
        check("neg_count", q_val.size(), 2);
        if (q_val.size() == 2) begin
            check("neg_min", q_val[0], 16'h8000);
            check("neg_one", q_val[1], 16'hFFFF);
            check("neg_spacing", q_cyc[1] - q_cyc[0], 16);
            check("neg_idx0", q_idx[0], 1);
            check("neg_idx1", q_idx[1], 2);
            $display("negative: %0d then %0d, spacing %0d", $signed(q_val[0]),
                     $signed(q_val[1]), q_cyc[1] - q_cyc[0]);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_word();
        test_reset_mid_word();
        test_full_frame();
        test_sync_err();
        test_realign();
        test_back_to_back_neg();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
